// File: rtl/mem_port_responder_pkg.sv
// Shared definitions for the stack CPU memory port: default word/address
// widths used by the core, and the responder state encoding.
package mem_port_responder_pkg;

  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned DATA_W_DEF = 16;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WR   = 3'd1;
  localparam logic [2:0] ST_RDA  = 3'd2;
  localparam logic [2:0] ST_RDB  = 3'd3;
  localparam logic [2:0] ST_CAP  = 3'd4;

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    WR   = ST_WR,
    RDA  = ST_RDA,
    RDB  = ST_RDB,
    CAP  = ST_CAP
  } resp_state_e;

endpackage

// File: rtl/mem_port_responder.sv
// Memory-side responder for the stack CPU memory port. Serves one request at
// a time (optional write, then optional two-word read) against a single-port
// synchronous SRAM with 1-cycle read latency, returning mem[RADDR] and
// mem[RADDR+1] on o_OP1/o_OP2 with a one-cycle o_VALID pulse.
//
// Ports:
//   i_CLOCK, i_RESET_N         clock, async active-low reset
//   i_REQ / o_READY            request handshake (accept on i_REQ && o_READY)
//   f_WRITE, f_READ            request kind flags
//   i_WADDR, i_DATA, i_RADDR   request payload, latched on accept
//   o_OP1, o_OP2, o_VALID      read result words and completion pulse
//   o_SRAM_ADDR/WE/WDATA       registered SRAM controls
//   i_SRAM_RDATA               SRAM read data (cycle after the address)
module mem_port_responder
  import mem_port_responder_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              i_CLOCK,
  input  logic              i_RESET_N,
  input  logic              i_REQ,
  output logic              o_READY,
  input  logic              f_WRITE,
  input  logic              f_READ,
  input  logic [ADDR_W-1:0] i_WADDR,
  input  logic [DATA_W-1:0] i_DATA,
  input  logic [ADDR_W-1:0] i_RADDR,
  output logic [DATA_W-1:0] o_OP1,
  output logic [DATA_W-1:0] o_OP2,
  output logic              o_VALID,
  output logic [ADDR_W-1:0] o_SRAM_ADDR,
  output logic              o_SRAM_WE,
  output logic [DATA_W-1:0] o_SRAM_WDATA,
  input  logic [DATA_W-1:0] i_SRAM_RDATA
);

  resp_state_e       state;
  logic              read_q;
  logic [ADDR_W-1:0] raddr_q;

  // Request FSM. SRAM controls are loaded on the edge entering each state so
  // they are stable for the whole state; write payload goes straight into the
  // SRAM output registers on accept, so only the read half is kept.
  always_ff @(posedge i_CLOCK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      state        <= IDLE;
      read_q       <= 1'b0;
      raddr_q      <= '0;
      o_READY      <= 1'b1;
      o_VALID      <= 1'b0;
      o_OP1        <= '0;
      o_OP2        <= '0;
      o_SRAM_ADDR  <= '0;
      o_SRAM_WE    <= 1'b0;
      o_SRAM_WDATA <= '0;
    end else begin
      o_VALID   <= 1'b0;
      o_SRAM_WE <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_REQ) begin
            read_q  <= f_READ;
            raddr_q <= i_RADDR;
            if (f_WRITE) begin
              state        <= WR;
              o_READY      <= 1'b0;
              o_SRAM_ADDR  <= i_WADDR;
              o_SRAM_WE    <= 1'b1;
              o_SRAM_WDATA <= i_DATA;
            end else if (f_READ) begin
              state       <= RDA;
              o_READY     <= 1'b0;
              o_SRAM_ADDR <= i_RADDR;
            end else begin
              // Null request completes immediately.
              o_VALID <= 1'b1;
            end
          end
        end
        WR: begin
          if (read_q) begin
            state       <= RDA;
            o_SRAM_ADDR <= raddr_q;
          end else begin
            state   <= IDLE;
            o_READY <= 1'b1;
            o_VALID <= 1'b1;
          end
        end
        RDA: begin
          // Second word address wraps modulo 2^ADDR_W.
          state       <= RDB;
          o_SRAM_ADDR <= raddr_q + ADDR_W'(1);
        end
        RDB: begin
          state <= CAP;
          o_OP1 <= i_SRAM_RDATA;
        end
        CAP: begin
          state   <= IDLE;
          o_OP2   <= i_SRAM_RDATA;
          o_READY <= 1'b1;
          o_VALID <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          o_READY <= 1'b1;
        end
      endcase
    end
  end

endmodule
